// File: rtl/calc_op_scheduler.sv
// Shares one arithmetic unit (ADD/SUB/MUL/AND) between two requesters using round-robin arbitration.
// Latency: ADD/SUB/AND give rsp_valid one cycle after accept; MUL gives it 1+WIDTH cycles after accept.
// Backpressure: the response is held stable until rsp_ready is high; no request is accepted until IDLE is re-entered.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ena                    tile enable; gates acceptance of new requests only
//   reqN_valid/op/a/b      request from requester N (op: 00 ADD, 01 SUB, 10 MUL, 11 AND)
//   reqN_ready             request from requester N is accepted this cycle
//   rsp_valid/id/result    registered response: owner id and 2*WIDTH-bit result
//   rsp_ready              consumer takes the response
//   busy                   unit is executing or holding a response
module calc_op_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               req0_valid,
    input  logic [1:0]         req0_op,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [1:0]         req1_op,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_result,
    input  logic               rsp_ready,
    output logic               busy
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0]    OP_ADD    = 2'b00;
    localparam logic [1:0]    OP_SUB    = 2'b01;
    localparam logic [1:0]    OP_MUL    = 2'b10;
    localparam logic [1:0]    OP_AND    = 2'b11;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             r_id;
    logic             r_rsp_id;
    logic [RW-1:0]    r_rsp_result;
    logic [RW-1:0]    r_acc;
    logic [RW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_sel;
    logic             w_last_iter;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [RW-1:0]    w_a_ext;
    logic [RW-1:0]    w_b_ext;
    logic [RW-1:0]    w_alu;
    logic [RW-1:0]    w_addend;

    // Round-robin: on a tie the requester that did not win last time is granted.
    assign w_idle   = (r_state == S_IDLE);
    assign w_gnt0   = w_idle & ena & req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1   = w_idle & ena & req1_valid & (~req0_valid | ~r_last_grant);
    assign w_accept = w_gnt0 | w_gnt1;
    assign w_sel    = w_gnt1;

    assign w_op    = w_sel ? req1_op : req0_op;
    assign w_a     = w_sel ? req1_a  : req0_a;
    assign w_b     = w_sel ? req1_b  : req0_b;
    assign w_a_ext = {{WIDTH{1'b0}}, w_a};
    assign w_b_ext = {{WIDTH{1'b0}}, w_b};

    // Single-cycle ops are evaluated on the accept edge straight from the granted inputs.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = w_a_ext + w_b_ext;
            OP_SUB:  w_alu = w_a_ext - w_b_ext;
            OP_AND:  w_alu = w_a_ext & w_b_ext;
            default: w_alu = '0;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right each EXEC cycle,
    // so bit 0 of the multiplier is always B[i] for iteration i.
    assign w_addend    = r_mplier[0] ? r_mcand : '0;
    assign w_last_iter = (r_cnt == LAST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_nxt = (w_op == OP_MUL) ? S_EXEC : S_RESP;
            S_EXEC:  if (w_last_iter) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_id         <= w_sel;
            r_last_grant <= w_sel;
            r_mcand      <= w_a_ext;
            r_mplier     <= w_b;
            r_acc        <= '0;
            r_cnt        <= '0;
            if (w_op != OP_MUL) begin
                r_rsp_result <= w_alu;
                r_rsp_id     <= w_sel;
            end
        end else if (r_state == S_EXEC) begin
            r_acc    <= r_acc + w_addend;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            // The final partial product goes straight into the result register.
            if (w_last_iter) begin
                r_rsp_result <= r_acc + w_addend;
                r_rsp_id     <= r_id;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy       = ~w_idle;

endmodule
